// File: rtl/hit_stream_serializer.sv
// hit_stream_serializer: packs up to SAMPLES parallel hits per cycle into a FIFO and streams them one per cycle
// Ports: clk/rst (async active-high); hit_R18S/color_R18U/hit_valid_R18H parallel hit input;
// out_hit_S/out_color_U/out_valid_H/out_ready_H head stream; almost_full_H early-halt hint;
// overflow_H sticky drop flag; drop_count_U saturating drops; hit_count_U wrapping accepted hits.
module hit_stream_serializer #(
  parameter int SIGFIG = 24,
  parameter int AXIS = 3,
  parameter int COLORS = 3,
  parameter int SAMPLES = 3,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [SIGFIG-1:0] hit_R18S [SAMPLES][AXIS],
  input  logic [SIGFIG-1:0] color_R18U [COLORS],
  input  logic [SAMPLES-1:0] hit_valid_R18H,
  output logic signed [SIGFIG-1:0] out_hit_S [AXIS],
  output logic [SIGFIG-1:0] out_color_U [COLORS],
  output logic out_valid_H,
  input  logic out_ready_H,
  output logic almost_full_H,
  output logic overflow_H,
  output logic [15:0] drop_count_U,
  output logic [31:0] hit_count_U
);
  localparam int W = (AXIS + COLORS) * SIGFIG;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, n, free, acc, count_next;
  logic [CW-1:0] off [SAMPLES];
  logic pop;
  logic [16:0] dsum;
  logic [W-1:0] head;
  // off[l] is the compacted slot of lane l; lanes whose slot reaches free are the ones dropped
  always_comb begin
    n = '0;
    for (int l = 0; l < SAMPLES; l++) begin
      off[l] = n;
      n = n + CW'(hit_valid_R18H[l]);
    end
    free = CW'(DEPTH) - count;
    acc = (n <= free) ? n : free;
    pop = out_valid_H && out_ready_H;
    count_next = count + acc - CW'(pop);
    dsum = {1'b0, drop_count_U} + 17'(n - acc);
  end
  assign out_valid_H = count != '0;
  assign head = mem[rd_ptr];
  always_comb begin
    for (int a = 0; a < AXIS; a++)
      out_hit_S[a] = out_valid_H ? head[W-1-a*SIGFIG -: SIGFIG] : '0;
    for (int c = 0; c < COLORS; c++)
      out_color_U[c] = out_valid_H ? head[(COLORS-1-c)*SIGFIG +: SIGFIG] : '0;
  end
  always_ff @(posedge clk)
    for (int l = 0; l < SAMPLES; l++)
      if (hit_valid_R18H[l] && off[l] < free) begin
        for (int a = 0; a < AXIS; a++)
          mem[wr_ptr + off[l][PW-1:0]][W-1-a*SIGFIG -: SIGFIG] <= hit_R18S[l][a];
        for (int c = 0; c < COLORS; c++)
          mem[wr_ptr + off[l][PW-1:0]][(COLORS-1-c)*SIGFIG +: SIGFIG] <= color_R18U[c];
      end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      almost_full_H <= 1'b0;
      overflow_H <= 1'b0;
      drop_count_U <= '0;
      hit_count_U <= '0;
    end else begin
      wr_ptr <= wr_ptr + acc[PW-1:0];
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count_next;
      almost_full_H <= count_next >= CW'(DEPTH - SAMPLES);
      overflow_H <= overflow_H || (n != acc);
      drop_count_U <= dsum[16] ? 16'hFFFF : dsum[15:0];
      hit_count_U <= hit_count_U + 32'(acc);
    end
endmodule

// File: tb/tb_hit_stream_serializer.sv
// tb_hit_stream_serializer: randomized and directed checks of hit_stream_serializer against a queue model
module tb_hit_stream_serializer;
  localparam int SIG = 24, DEP = 16, SMP = 3;
  logic clk = 0, rst = 0;
  logic signed [SIG-1:0] hit [SMP][3];
  logic [SIG-1:0] color [3];
  logic [SMP-1:0] hv = '0;
  logic rdy = 0;
  logic signed [SIG-1:0] out_hit [3];
  logic [SIG-1:0] out_color [3];
  logic out_valid, afull, ovf;
  logic [15:0] drops;
  logic [31:0] hits;
  logic [143:0] q [$];
  int m_drop = 0;
  logic [31:0] m_hits = 0;
  logic m_ovf = 0, m_af = 0;
  int n_chk = 0, n_fail = 0;

  hit_stream_serializer dut (
    .clk(clk), .rst(rst), .hit_R18S(hit), .color_R18U(color), .hit_valid_R18H(hv),
    .out_hit_S(out_hit), .out_color_U(out_color), .out_valid_H(out_valid), .out_ready_H(rdy),
    .almost_full_H(afull), .overflow_H(ovf), .drop_count_U(drops), .hit_count_U(hits));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] dut_pkt();
    return {out_hit[0], out_hit[1], out_hit[2], out_color[0], out_color[1], out_color[2]};
  endfunction

  task automatic rand_data();
    for (int l = 0; l < SMP; l++) for (int a = 0; a < 3; a++) hit[l][a] = SIG'($urandom);
    for (int c = 0; c < 3; c++) color[c] = SIG'($urandom);
  endtask

  task automatic set_data(input int base, input int c0);
    for (int l = 0; l < SMP; l++) for (int a = 0; a < 3; a++) hit[l][a] = SIG'(base + 6 * l + a);
    for (int c = 0; c < 3; c++) color[c] = SIG'(c0 + 10 * c);
  endtask

  task automatic check_all();
    check("valid", out_valid, q.size() != 0);
    check("data", dut_pkt(), q.size() != 0 ? q[0] : 144'd0);
    check("afull", afull, m_af);
    check("ovf", ovf, m_ovf);
    check("drops", drops, m_drop);
    check("hits", hits, m_hits);
  endtask

  task automatic step(input logic [SMP-1:0] v, input logic r);
    int free, took;
    hv = v;
    rdy = r;
    free = DEP - q.size();
    if (q.size() != 0 && r) void'(q.pop_front());
    took = 0;
    for (int l = 0; l < SMP; l++)
      if (v[l]) begin
        if (took < free) begin
          q.push_back({hit[l][0], hit[l][1], hit[l][2], color[0], color[1], color[2]});
          took++;
        end else begin
          m_ovf = 1;
          m_drop = (m_drop == 65535) ? 65535 : m_drop + 1;
        end
      end
    m_hits += 32'(took);
    m_af = q.size() >= DEP - SMP;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0;
    m_hits = 0;
    m_ovf = 0;
    m_af = 0;
  endtask

  initial begin
    set_data(0, 0);
    rst = 1;
    #12;
    check_all();
    rst = 0;
    @(negedge clk);
    // test 1: two hits, in lane order
    set_data(0, 0);
    hit[0][0] = 1; hit[0][1] = 2; hit[0][2] = 3;
    hit[2][0] = 7; hit[2][1] = 8; hit[2][2] = 9;
    color[0] = 10; color[1] = 20; color[2] = 30;
    step(3'b101, 1);
    check("t1_first", dut_pkt(), {24'd1, 24'd2, 24'd3, 24'd10, 24'd20, 24'd30});
    step(3'b000, 1);
    check("t1_second", dut_pkt(), {24'd7, 24'd8, 24'd9, 24'd10, 24'd20, 24'd30});
    check("t1_hits", hits, 32'd2);
    step(3'b000, 1);
    check("t1_empty", {out_valid, dut_pkt()}, 145'd0);
    // test 2: fill to overflow
    for (int i = 0; i < 5; i++) begin
      set_data(100 * i, i);
      step(3'b111, 0);
    end
    check("t2_ovf_before", ovf, 1'b0);
    set_data(900, 5);
    step(3'b111, 0);
    check("t2_drops", drops, 16'd2);
    check("t2_ovf", ovf, 1'b1);
    // test 3: full with simultaneous pop gives no push credit
    step(3'b001, 1);
    check("t3_drops", drops, 16'd3);
    // drain, then test 4: 2 in, 1 out every other cycle
    for (int i = 0; i < 16; i++) step(3'b000, 1);
    for (int i = 0; i < 14; i++) begin
      set_data(1000 + 10 * i, i);
      step(3'b011, i[0] == 0);
    end
    // test 5: async reset with count 9
    rst = 1; #1; rst = 0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step(3'b111, 0);
    end
    #2;
    rst = 1;
    #1;
    model_reset();
    check("t5_async", {out_valid, afull, ovf, drops, hits}, 51'd0);
    @(negedge clk);
    rst = 0;
    set_data(4242, 77);
    step(3'b100, 1);
    check("t5_first", out_hit[0], SIG'(4242 + 12));
    // random phase
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      step(SMP'($urandom), 1'($urandom));
    end
    // test 6: saturate drop counter
    for (int i = 0; i < 22000; i++) begin
      rand_data();
      step(3'b111, 0);
    end
    check("t6_sat", drops, 16'hFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
